// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external ALU between two requesters. In IDLE it grants one
//   pending request and pulses that requester's ack. It then drives the
//   winner's operands and opcode select lines to the ALU, waits LAT cycles,
//   and returns the ALU result as a one-cycle response tagged with the
//   winner's id. This block does no arithmetic of its own.
//
//   An illegal opcode is one that is not one-hot: no bit set, or more than
//   one bit set. Such a request is still acked. The ALU selects stay low,
//   and one cycle later an error response with zero data is returned.
//
// Configuration:
//   ALU_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate.
//                            The requester that was not granted last wins.
//                            When undefined, requester 0 always wins, and
//                            no last-grant state exists.
//
// Parameters:
//   WIDTH - operand width in bits
//   LAT   - latency of the shared ALU in cycles (1..15)
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   req[1:0]            request per requester
//   op1_0, op2_0, opc_0 requester 0 operands and one-hot opcode {add,sub,cmp}
//   op1_1, op2_1, opc_1 requester 1 operands and one-hot opcode {add,sub,cmp}
//   ack[1:0]            one-cycle acceptance pulse per requester
//   alu_op1, alu_op2    operands presented to the shared ALU
//   alu_add/sub/cmp     ALU operation selects
//   alu_result          ALU result including the carry/borrow bit
//   resp_valid          one-cycle response strobe
//   resp_id             requester that owns the response
//   resp_data           captured ALU result (zero on error)
//   resp_err            response reports an illegal opcode
//   busy                high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] op1_0,
    input  logic [WIDTH-1:0] op2_0,
    input  logic [2:0]       opc_0,
    input  logic [WIDTH-1:0] op1_1,
    input  logic [WIDTH-1:0] op2_1,
    input  logic [2:0]       opc_1,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_cmp,
    input  logic [WIDTH:0]   alu_result,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH:0]   resp_data,
    output logic             resp_err,
    output logic             busy
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_ack;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic               r_add;
    logic               r_sub;
    logic               r_cmp;
    logic               r_win;       // requester owning the transaction in flight
    logic               r_illegal;   // transaction in flight carries an illegal opcode
    logic               r_resp_valid;
    logic               r_resp_id;
    logic [WIDTH:0]     r_resp_data;
    logic               r_resp_err;
    logic               r_busy;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic               r_last;      // requester granted most recently
`endif

    logic               w_grant1;    // 1: requester 1 wins this cycle
    logic [2:0]         w_opc;
    logic [WIDTH-1:0]   w_op1;
    logic [WIDTH-1:0]   w_op2;
    logic               w_legal;

    // Winner selection. A single request always wins. Simultaneous requests
    // are resolved by priority or by alternation.
    always_comb begin
        w_grant1 = 1'b0;
        if (req == 2'b10) begin
            w_grant1 = 1'b1;
        end else if (req == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            w_grant1 = ~r_last;
`else
            w_grant1 = 1'b0;
`endif
        end
    end

    assign w_opc   = w_grant1 ? opc_1 : opc_0;
    assign w_op1   = w_grant1 ? op1_1 : op1_0;
    assign w_op2   = w_grant1 ? op2_1 : op2_0;
    assign w_legal = (w_opc == 3'b100) || (w_opc == 3'b010) || (w_opc == 3'b001);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ack        <= 2'b00;
            r_op1        <= '0;
            r_op2        <= '0;
            r_add        <= 1'b0;
            r_sub        <= 1'b0;
            r_cmp        <= 1'b0;
            r_win        <= 1'b0;
            r_illegal    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            r_last       <= 1'b1;
`endif
        end else begin
            // ack is a pulse, so it clears unless a grant happens this edge.
            r_ack <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_ack     <= w_grant1 ? 2'b10 : 2'b01;
                        r_op1     <= w_op1;
                        r_op2     <= w_op2;
                        // Selects go to the ALU only when the opcode is legal.
                        r_add     <= w_legal & w_opc[2];
                        r_sub     <= w_legal & w_opc[1];
                        r_cmp     <= w_legal & w_opc[0];
                        r_win     <= w_grant1;
                        r_illegal <= ~w_legal;
                        r_cnt     <= w_legal ? CNT_W'(LAT - 1) : '0;
                        r_state   <= S_WAIT;
                        r_busy    <= 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        r_last    <= w_grant1;
`endif
                    end
                end
                S_WAIT: begin
                    // An illegal request skips the ALU wait and errors one
                    // cycle after its grant.
                    if (r_illegal) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_win;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_cnt == '0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_win;
                        r_resp_data  <= alu_result;
                        r_resp_err   <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign alu_op1    = r_op1;
    assign alu_op2    = r_op2;
    assign alu_add    = r_add;
    assign alu_sub    = r_sub;
    assign alu_cmp    = r_cmp;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] op1_0, op2_0, op1_1, op2_1;
    logic [2:0]       opc_0, opc_1;
    logic [1:0]       ack;
    logic [WIDTH-1:0] alu_op1, alu_op2;
    logic             alu_add, alu_sub, alu_cmp;
    logic [WIDTH:0]   alu_result;
    logic             resp_valid, resp_id, resp_err, busy;
    logic [WIDTH:0]   resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req),
        .op1_0(op1_0), .op2_0(op2_0), .opc_0(opc_0),
        .op1_1(op1_1), .op2_1(op2_1), .opc_1(opc_1),
        .ack(ack), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_cmp(alu_cmp),
        .alu_result(alu_result), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    // Reference arithmetic for a one-hot opcode {add,sub,cmp}.
    function automatic logic [WIDTH:0] calc(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0] opc);
        case (opc)
            3'b100:         calc = {1'b0, a} + {1'b0, b};
            3'b010, 3'b001: calc = {1'b0, a} - {1'b0, b};
            default:        calc = '0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] opc);
        is_legal = (opc == 3'b100) || (opc == 3'b010) || (opc == 3'b001);
    endfunction

    // The external ALU, driven by the DUT's select lines.
    always_comb begin
        alu_result = '0;
        if (alu_add)
            alu_result = calc(alu_op1, alu_op2, 3'b100);
        else if (alu_sub || alu_cmp)
            alu_result = calc(alu_op1, alu_op2, 3'b010);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-timeline model + compare ----------------
    int               n = 0;
    int               m_grant, m_free, m_resp;
    logic             m_last;
    logic [1:0]       m_ackv;
    logic [WIDTH-1:0] m_op1, m_op2;
    logic [2:0]       m_sel;
    logic [WIDTH:0]   m_data, m_pdata;
    logic             m_id, m_err, m_pid, m_perr;
    logic             s_rst;
    logic [1:0]       s_req;
    logic [WIDTH-1:0] s_a0, s_b0, s_a1, s_b1;
    logic [2:0]       s_c0, s_c1;

    initial begin : cmp_proc
        logic             w;
        logic [2:0]       opc;
        logic [WIDTH-1:0] a, b;
        m_grant = -100; m_free = 0; m_resp = -100; m_last = 1'b1;
        m_op1 = '0; m_op2 = '0; m_sel = '0; m_data = '0; m_id = 1'b0; m_err = 1'b0;
        forever begin
            @(posedge clk);
            s_rst = reset; s_req = req;
            s_a0 = op1_0; s_b0 = op2_0; s_c0 = opc_0;
            s_a1 = op1_1; s_b1 = op2_1; s_c1 = opc_1;
            #1;
            n++;
            if (s_rst) begin
                m_grant = -100; m_free = 0; m_resp = -100; m_last = 1'b1;
                m_op1 = '0; m_op2 = '0; m_sel = '0; m_data = '0; m_id = 1'b0; m_err = 1'b0;
            end else begin
                if (n >= m_free && s_req != 2'b00) begin
                    if (s_req == 2'b10)      w = 1'b1;
                    else if (s_req == 2'b01) w = 1'b0;
                    else begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        w = ~m_last;
`else
                        w = 1'b0;
`endif
                    end
                    m_last = w;
                    opc = w ? s_c1 : s_c0;
                    a   = w ? s_a1 : s_a0;
                    b   = w ? s_b1 : s_b0;
                    m_grant = n;
                    m_ackv  = w ? 2'b10 : 2'b01;
                    m_op1   = a;
                    m_op2   = b;
                    m_sel   = is_legal(opc) ? opc : 3'b000;
                    m_pdata = is_legal(opc) ? calc(a, b, opc) : '0;
                    m_perr  = ~is_legal(opc);
                    m_pid   = w;
                    m_resp  = is_legal(opc) ? n + LAT : n + 1;
                    m_free  = is_legal(opc) ? n + LAT + 2 : n + 3;
                end
                if (n == m_resp) begin
                    m_data = m_pdata; m_id = m_pid; m_err = m_perr;
                end
            end
            chk("ack", 64'(ack), 64'((!s_rst && n == m_grant) ? m_ackv : 2'b00));
            chk("resp_valid", 64'(resp_valid), 64'(!s_rst && n == m_resp));
            chk("busy", 64'(busy), 64'(!s_rst && n >= m_grant && n <= m_free - 2));
            chk("alu_op1", 64'(alu_op1), 64'(m_op1));
            chk("alu_op2", 64'(alu_op2), 64'(m_op2));
            chk("alu_sel", 64'({alu_add, alu_sub, alu_cmp}), 64'(m_sel));
            chk("resp_data", 64'(resp_data), 64'(m_data));
            if (s_rst || n == m_resp) begin
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_err", 64'(resp_err), 64'(m_err));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic wait_ack(input string tag, output logic ok);
        int t;
        t = 0; ok = 1'b0;
        while (t < 40) begin
            @(posedge clk); #1; t++;
            if (ack != 2'b00) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_ack_timeout actual=none required=ack", tag);
        end
    endtask

    task automatic wait_resp(input string tag, output int lat, output logic ok);
        lat = 0; ok = 1'b0;
        while (lat < 40) begin
            @(posedge clk); #1; lat++;
            if (resp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_resp_timeout actual=none required=resp_valid", tag);
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] r, input logic [1:0] exp_ack,
                           input logic [WIDTH:0] exp_data, input logic exp_err, input int exp_lat);
        logic ok;
        int   lat;
        @(negedge clk);
        req = r;
        wait_ack(tag, ok);
        if (ok) begin
            chk({tag, "_ack"}, 64'(ack), 64'(exp_ack));
            if (exp_err) chk({tag, "_sel_zero"}, 64'({alu_add, alu_sub, alu_cmp}), 64'(3'b000));
            req = 2'b00;
            wait_resp(tag, lat, ok);
            if (ok) begin
                chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
                chk({tag, "_id"}, 64'(resp_id), 64'(exp_ack[1]));
                chk({tag, "_data"}, 64'(resp_data), 64'(exp_data));
                chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
            end
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    int   order[3];
    int   exp_order[3];
    logic ok;
    int   lat;

    initial begin
        reset = 1'b1; req = 2'b00;
        op1_0 = '0; op2_0 = '0; opc_0 = 3'b000;
        op1_1 = '0; op2_1 = '0; opc_1 = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_resp_data", 64'(resp_data), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // add on requester 0: 5 + 3
        op1_0 = 32'h5; op2_0 = 32'h3; opc_0 = 3'b100;
        run_txn("add0", 2'b01, 2'b01, 33'h0_0000_0008, 1'b0, LAT);
        // sub on requester 1: 0 - 1 leaves the borrow bit set
        op1_1 = 32'h0; op2_1 = 32'h1; opc_1 = 3'b010;
        run_txn("sub1", 2'b10, 2'b10, 33'h1_FFFF_FFFF, 1'b0, LAT);
        // add with carry out
        op1_0 = 32'hFFFF_FFFF; op2_0 = 32'hFFFF_FFFF; opc_0 = 3'b100;
        run_txn("addc0", 2'b01, 2'b01, 33'h1_FFFF_FFFE, 1'b0, LAT);
        // cmp on requester 1: 9 - 7
        op1_1 = 32'h9; op2_1 = 32'h7; opc_1 = 3'b001;
        run_txn("cmp1", 2'b10, 2'b10, 33'h0_0000_0002, 1'b0, LAT);
        // illegal opcodes: two bits set, and no bit set
        op1_0 = 32'h11; op2_0 = 32'h22; opc_0 = 3'b110;
        run_txn("ill0", 2'b01, 2'b01, 33'h0, 1'b1, 1);
        opc_1 = 3'b000;
        run_txn("ill1", 2'b10, 2'b10, 33'h0, 1'b1, 1);

        // Three grants with both requests held, starting from reset.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        op1_0 = 32'h10; op2_0 = 32'h1; opc_0 = 3'b100;
        op1_1 = 32'h20; op2_1 = 32'h2; opc_1 = 3'b010;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        @(negedge clk); req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_ack("both", ok);
            order[i] = (ack == 2'b10) ? 1 : 0;
            wait_resp("both", lat, ok);
            chk("both_data", 64'(resp_data),
                64'(order[i] == 1 ? 33'h0_0000_001E : 33'h0_0000_0011));
        end
        req = 2'b00;
        for (int i = 0; i < 3; i++) chk("grant_order", 64'(order[i]), 64'(exp_order[i]));
        repeat (2) @(negedge clk);

        // Reset while the transaction is in WAIT drops it.
        op1_0 = 32'h7; op2_0 = 32'h8; opc_0 = 3'b100;
        @(negedge clk); req = 2'b01;
        wait_ack("abort", ok);
        req = 2'b00;
        @(negedge clk); reset = 1'b1;
        #1;
        chk("abort_ack", 64'(ack), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_op1", 64'(alu_op1), 64'(0));
        chk("abort_add", 64'(alu_add), 64'(0));
        chk("abort_resp_data", 64'(resp_data), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 64'(resp_valid), 64'(0));
        end

        // Normal operation resumes afterwards.
        op1_1 = 32'h64; op2_1 = 32'h1; opc_1 = 3'b100;
        run_txn("after", 2'b10, 2'b10, 33'h0_0000_0065, 1'b0, LAT);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter LAT, default 2, shared ALU latency in cycles (legal 1..15).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  2  request per requester (bit i = requester i).
REQ-007 op1_0, op2_0  input  WIDTH each  requester 0 operands.
REQ-008 opc_0  input  3  requester 0 opcode, one-hot {add,sub,cmp}.
REQ-009 op1_1, op2_1, opc_1  input  WIDTH/WIDTH/3  requester 1 operands and opcode.
REQ-010 ack  output  2  one-cycle acceptance pulse per requester.
REQ-011 alu_op1, alu_op2  output  WIDTH each  operands driven to the shared ALU.
REQ-012 alu_add, alu_sub, alu_cmp  output  1 each  ALU operation selects.
REQ-013 alu_result  input  WIDTH+1  ALU result including carry/borrow bit.
REQ-014 resp_valid  output  1  one-cycle response strobe.
REQ-015 resp_id  output  1  requester the response belongs to.
REQ-016 resp_data  output  WIDTH+1  captured ALU result.
REQ-017 resp_err  output  1  response flags an illegal opcode.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-020 In IDLE with any req bit set, at edge k the block SHALL pick a winner, pulse ack[winner] for exactly one cycle, and load alu_op1/alu_op2/alu_add/alu_sub/alu_cmp from the winner's inputs.
REQ-021 A requester SHALL hold req, operands and opcode stable until it sees its ack; ack is never asserted for a requester whose req is low.
REQ-022 For a legal opcode (exactly one bit set), the FSM SHALL enter WAIT and load a down-counter with LAT-1.
REQ-023 In WAIT the counter SHALL decrement each edge; at edge k+LAT the block SHALL capture alu_result into resp_data, set resp_valid=1, resp_id=winner, resp_err=0 and enter RESP.
REQ-024 In RESP, the next edge SHALL clear resp_valid and return to IDLE; alu_* outputs SHALL hold their values until the next grant; resp_data SHALL hold until the next response.
REQ-025 For an illegal opcode (zero or multiple bits set), the block SHALL still ack, SHALL keep alu_add/alu_sub/alu_cmp at 0, and at edge k+1 SHALL assert resp_valid with resp_err=1 and resp_data=0, then enter RESP.
REQ-026 No request SHALL be sampled outside IDLE; the minimum spacing between grants is LAT+2 cycles (legal) or 3 cycles (illegal).
REQ-027 resp_data SHALL carry alu_result unmodified for add, sub and cmp; no arithmetic is performed in this block.
REQ-028 A requester deasserting req before its ack SHALL simply not be granted; there SHALL be no protocol error.

Reset
REQ-029 While reset is high: state=IDLE, counter=0, ack=0, alu_op1=alu_op2=0, alu_add=alu_sub=alu_cmp=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0, last-grant register=1.
REQ-030 Reset during WAIT or RESP SHALL drop the transaction; no response for it SHALL ever be produced.

Configuration
REQ-031 With ALU_ARB_ROUND_ROBIN_EN defined, when both req bits are high the block SHALL grant the requester not recorded in the last-grant register, which is updated on every grant; with a single request, that requester SHALL win.
REQ-032 Without ALU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win on simultaneous requests, and the last-grant register SHALL be absent.

Verification
REQ-033 WIDTH=32, LAT=2, req=01, op1_0=0x00000005, op2_0=0x00000003, opc_0=add, ALU model returns 0x000000008 -> ack=01 at edge k, resp_valid at edge k+2, resp_id=0, resp_data=0x000000008, resp_err=0.
REQ-034 req=10, op1_1=0x00000000, op2_1=0x00000001, opc_1=sub, ALU returns 0x1FFFFFFFF -> ack=10, resp_id=1, resp_data=0x1FFFFFFFF.
REQ-035 With round-robin enabled, req=11 held for three transactions after reset -> grants ordered 0,1,0; with it disabled -> 0,0,0.
REQ-036 opc_0=3'b110 -> ack=01, alu selects stay 0, resp_valid at edge k+1 with resp_err=1 and resp_data=0.
REQ-037 Reset asserted one cycle after ack in WAIT -> all outputs return to REQ-029 values immediately, and no resp_valid occurs before the next ack.
